// File: rtl/gray_cnt_arb.sv
// gray_cnt_arb: round-robin arbiter sequencing one shared Gray step counter among NREQ requesters (optional WATCHDOG_EN)
// Ports: Clk, Reset (sync, active-high); Req[NREQ] level requests; Grant[NREQ] one-hot owner; Owner index;
//        Busy in CLEAR/RUN; Done[NREQ] completion pulse; Err watchdog-abort pulse (0 without WATCHDOG_EN);
//        Cnt_Reset/Cnt_En drive the shared counter; Cnt_Overflow is its sticky overflow flag.
module gray_cnt_arb #(
  parameter int NREQ     = 4,
  parameter int IDXW     = 2,
  parameter int WD_LIMIT = 32
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic [NREQ-1:0] Req,
  output logic [NREQ-1:0] Grant,
  output logic [IDXW-1:0] Owner,
  output logic            Busy,
  output logic [NREQ-1:0] Done,
  output logic            Err,
  output logic            Cnt_Reset,
  output logic            Cnt_En,
  input  logic            Cnt_Overflow
);
  typedef enum logic [1:0] {IDLE, CLEAR, RUN} state_t;
  state_t            r_state, w_next;
  logic [NREQ-1:0]   r_grant, r_done, w_onehot;
  logic [IDXW-1:0]   r_owner, r_last, w_pick;
  logic              w_take, w_ovf_end, w_wd_hit;
  if (NREQ < 2 || NREQ > 8 || IDXW < $clog2(NREQ) || WD_LIMIT < 1) begin : g_bad_params
    $error("gray_cnt_arb: parameter out of range");
  end
  // Nearest set bit after r_last wins: scanning from farthest to nearest lets the nearest overwrite.
  always_comb begin
    w_pick = '0;
    for (int i = NREQ; i >= 1; i--)
      if (Req[IDXW'((int'(r_last) + i) % NREQ)]) w_pick = IDXW'((int'(r_last) + i) % NREQ);
  end
  assign w_onehot  = {{(NREQ-1){1'b0}}, 1'b1} << w_pick;
  assign w_take    = (r_state == IDLE) && (|Req);
  assign w_ovf_end = (r_state == RUN) && Cnt_Overflow;
`ifdef WATCHDOG_EN
  localparam int WDW = $clog2(WD_LIMIT + 1);
  logic [WDW-1:0] r_wd;
  logic           r_err;
  // Held at zero outside RUN, so it starts from zero on every RUN entry.
  always_ff @(posedge Clk)
    r_wd <= (Reset || r_state != RUN) ? '0 : r_wd + 1'b1;
  // Overflow in the limit cycle takes precedence, so the watchdog only fires without it.
  assign w_wd_hit = (r_state == RUN) && !Cnt_Overflow && (r_wd == WDW'(WD_LIMIT - 1));
  always_ff @(posedge Clk)
    r_err <= !Reset && w_wd_hit;
  assign Err = r_err;
`else
  assign w_wd_hit = 1'b0;
  assign Err      = 1'b0;
`endif
  always_ff @(posedge Clk)
    r_state <= Reset ? IDLE : w_next;
  always_comb
    w_next = (r_state == IDLE)  ? (w_take ? CLEAR : IDLE) :
             (r_state == CLEAR) ? RUN :
             (r_state == RUN)   ? ((w_ovf_end || w_wd_hit) ? IDLE : RUN) : IDLE;
  always_comb begin
    Busy      = r_state != IDLE;
    Cnt_Reset = Reset || (r_state == CLEAR);
    Cnt_En    = (r_state == RUN) && Req[r_owner] && !Cnt_Overflow;
  end
  always_ff @(posedge Clk)
    if (Reset) begin
      r_grant <= '0;
      r_done  <= '0;
      r_owner <= '0;
      r_last  <= IDXW'(NREQ - 1);
    end else begin
      r_done  <= w_ovf_end ? r_grant : '0;
      r_grant <= w_take ? w_onehot : (w_ovf_end || w_wd_hit) ? '0 : r_grant;
      if (w_take) begin
        r_owner <= w_pick;
        r_last  <= w_pick;
      end
    end
  assign Grant = r_grant;
  assign Owner = r_owner;
  assign Done  = r_done;
endmodule

// File: tb/tb_gray_cnt_arb.sv
// tb_gray_cnt_arb: directed bench for gray_cnt_arb with a behavioural model of the shared counter
module tb_gray_cnt_arb;
  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic [3:0] Req = '0;
  logic [3:0] Grant, Done;
  logic [1:0] Owner;
  logic       Busy, Err, Cnt_Reset, Cnt_En, Cnt_Overflow;
  logic [2:0] m_cnt = '0;
  logic       m_ovf = 1'b0;
  logic       ovf_sel = 1'b0;
  logic       ovf_drv = 1'b0;
  int         errors = 0;
  int         checks = 0;
  int         en_cnt;
  gray_cnt_arb #(.NREQ(4), .IDXW(2), .WD_LIMIT(32)) dut (
    .Clk(Clk), .Reset(Reset), .Req(Req), .Grant(Grant), .Owner(Owner), .Busy(Busy),
    .Done(Done), .Err(Err), .Cnt_Reset(Cnt_Reset), .Cnt_En(Cnt_En), .Cnt_Overflow(Cnt_Overflow)
  );
  always #5 Clk = ~Clk;
  always @(posedge Clk)
    if (Cnt_Reset) begin
      m_cnt <= '0;
      m_ovf <= 1'b0;
    end else if (Cnt_En) begin
      m_cnt <= m_cnt + 3'd1;
      if (m_cnt == 3'd7) m_ovf <= 1'b1;
    end
  assign Cnt_Overflow = ovf_sel ? ovf_drv : m_ovf;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic nxt();
    @(posedge Clk);
    #1;
  endtask
  task automatic do_reset();
    Reset = 1'b1;
    Req   = '0;
    nxt();
    #1;
    chk("rst_cnt_reset", {31'd0, Cnt_Reset}, 1);
    chk("rst_grant", {28'd0, Grant}, 0);
    chk("rst_busy", {31'd0, Busy}, 0);
    chk("rst_owner", {30'd0, Owner}, 0);
    nxt();
    Reset = 1'b0;
  endtask
  initial begin
    do_reset();
    for (int k = 0; k <= 11; k++) begin
      if (k > 0) nxt();
      Req = (k == 11) ? 4'b0000 : 4'b0001;
      #1;
      chk($sformatf("t1_grant_c%0d", k), {28'd0, Grant}, (k >= 1 && k <= 10) ? 1 : 0);
      chk($sformatf("t1_clr_c%0d", k), {31'd0, Cnt_Reset}, (k == 1) ? 1 : 0);
      chk($sformatf("t1_en_c%0d", k), {31'd0, Cnt_En}, (k >= 2 && k <= 9) ? 1 : 0);
      chk($sformatf("t1_done_c%0d", k), {28'd0, Done}, (k == 11) ? 1 : 0);
      if (k == 5) chk("t1_owner", {30'd0, Owner}, 0);
    end
    do_reset();
    en_cnt = 0;
    for (int k = 0; k <= 55; k++) begin
      if (k > 0) nxt();
      Req = 4'b1111;
      #1;
      if (k == 0) chk("t2_idle_grant", {28'd0, Grant}, 0);
      else begin
        automatic int t  = (k - 1) / 11;
        automatic int ph = (k - 1) % 11 + 1;
        if (Cnt_En) en_cnt++;
        if (ph == 1) begin
          chk($sformatf("t2_grant_t%0d", t), {28'd0, Grant}, 32'd1 << (t % 4));
          chk($sformatf("t2_owner_t%0d", t), {30'd0, Owner}, t % 4);
        end
        if (ph == 11) begin
          chk($sformatf("t2_done_t%0d", t), {28'd0, Done}, 32'd1 << (t % 4));
          chk($sformatf("t2_gap_t%0d", t), {28'd0, Grant}, 0);
          chk($sformatf("t2_encnt_t%0d", t), en_cnt, 8);
          en_cnt = 0;
        end
      end
    end
    do_reset();
    for (int k = 0; k <= 16; k++) begin
      if (k > 0) nxt();
      Req = ((k >= 5 && k <= 9) || k == 16) ? 4'b0000 : 4'b0001;
      #1;
      chk($sformatf("t3_en_c%0d", k), {31'd0, Cnt_En}, ((k >= 2 && k <= 4) || (k >= 10 && k <= 14)) ? 1 : 0);
      if (k == 7) chk("t3_grant_held", {28'd0, Grant}, 1);
      if (k == 15) chk("t3_done_c15", {28'd0, Done}, 0);
      if (k == 16) chk("t3_done_c16", {28'd0, Done}, 1);
    end
    do_reset();
    for (int k = 0; k <= 9; k++) begin
      if (k > 0) nxt();
      Reset = (k == 6 || k == 7);
      Req   = (k <= 6) ? 4'b0001 : (k == 7) ? 4'b0000 : 4'b1001;
      #1;
      if (k == 5) chk("t4_en_c5", {31'd0, Cnt_En}, 1);
      if (k == 6) chk("t4_clr_c6", {31'd0, Cnt_Reset}, 1);
      if (k == 7) begin
        chk("t4_grant_c7", {28'd0, Grant}, 0);
        chk("t4_busy_c7", {31'd0, Busy}, 0);
        chk("t4_clr_c7", {31'd0, Cnt_Reset}, 1);
      end
      if (k >= 7 && k <= 8) chk($sformatf("t4_nodone_c%0d", k), {28'd0, Done}, 0);
      if (k == 9) chk("t4_rr_restart", {28'd0, Grant}, 1);
    end
`ifdef WATCHDOG_EN
    do_reset();
    ovf_sel = 1'b1;
    ovf_drv = 1'b0;
    for (int k = 0; k <= 35; k++) begin
      if (k > 0) nxt();
      Req = 4'b0011;
      #1;
      if (k == 33) begin
        chk("t5_err_c33", {31'd0, Err}, 0);
        chk("t5_grant_c33", {28'd0, Grant}, 1);
      end
      if (k == 34) begin
        chk("t5_err_c34", {31'd0, Err}, 1);
        chk("t5_done_c34", {28'd0, Done}, 0);
        chk("t5_grant_c34", {28'd0, Grant}, 0);
      end
      if (k == 35) begin
        chk("t5_next_grant", {28'd0, Grant}, 2);
        chk("t5_err_c35", {31'd0, Err}, 0);
      end
    end
    do_reset();
    ovf_drv = 1'b0;
    for (int k = 0; k <= 34; k++) begin
      if (k > 0) nxt();
      Req = 4'b0001;
      if (k == 33) ovf_drv = 1'b1;
      #1;
      if (k == 33) chk("t6_done_c33", {28'd0, Done}, 0);
      if (k == 34) begin
        chk("t6_done_c34", {28'd0, Done}, 1);
        chk("t6_err_c34", {31'd0, Err}, 0);
        chk("t6_grant_c34", {28'd0, Grant}, 0);
      end
    end
    ovf_sel = 1'b0;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
